// File: rtl/bridge_window_if.sv
// C64-side bus and bridge-RAM port bundle for bridge_window_ctrl.
// The slave modport is the controller's view; master is the bus/RAM environment.
interface bridge_window_if;
  logic        phi2_in;
  logic [15:0] c64_addr;
  logic        c64_rw;
  logic [7:0]  c64_data_in;
  logic        win_enable;
  logic [7:0]  c64_data_out;
  logic        c64_data_oe;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        ram_en;
  logic        ram_we;

  modport master (
    output phi2_in, c64_addr, c64_rw, c64_data_in, win_enable, ram_dout,
    input  c64_data_out, c64_data_oe, ram_addr, ram_din, ram_en, ram_we
  );

  modport slave (
    input  phi2_in, c64_addr, c64_rw, c64_data_in, win_enable, ram_dout,
    output c64_data_out, c64_data_oe, ram_addr, ram_din, ram_en, ram_we
  );
endinterface

// File: rtl/bridge_window_ctrl.sv
// Maps a 256-byte page of the C64 address space onto a bridge RAM, one access
// per phi2 cycle, with phi2 synchronised into the clk domain.
module bridge_window_ctrl #(
  parameter logic [7:0] WIN_PAGE   = 8'hDE,
  parameter int         SETTLE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  bridge_window_if.slave  bus,
  output logic [15:0]     hit_count,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    IDLE, SETTLE, RD_ISSUE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_COMMIT, MISS_WAIT
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  sync_q;
  logic [1:0]  fill;
  logic        armed;
  logic        rise, fall;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  addr_q, wdata_q, rdata_q;
  logic [15:0] hit_cnt;
  logic        hit_now;
  logic        sample, wr_cap, rd_cap, cnt_inc;
  logic        ram_en_c, ram_we_c, oe_c;

  // A rise is only honoured once phi2 has been seen low after reset, so a
  // phi2 that is already high at reset release is not mistaken for a new cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      fill   <= '0;
      armed  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], bus.phi2_in};
      if (fill != 2'd3) fill <= fill + 2'd1;
      else if (!sync_q[1]) armed <= 1'b1;
    end
  end

  assign rise    = armed & sync_q[1] & ~sync_q[2];
  assign fall    = ~sync_q[1] & sync_q[2];
  assign hit_now = bus.win_enable && (bus.c64_addr[15:8] == WIN_PAGE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ram_en_c  = 1'b0;
    ram_we_c  = 1'b0;
    oe_c      = 1'b0;
    sample    = 1'b0;
    wr_cap    = 1'b0;
    rd_cap    = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = SETTLE;
          cnt_nxt   = 4'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        if (fall) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          sample = 1'b1;
          if (!hit_now)         state_nxt = MISS_WAIT;
          else if (bus.c64_rw)  state_nxt = RD_ISSUE;
          else begin
            state_nxt = WR_WAIT;
            wr_cap    = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RD_ISSUE: begin
        ram_en_c  = 1'b1;
        state_nxt = fall ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        rd_cap = 1'b1;
        if (fall) state_nxt = IDLE;
        else begin
          state_nxt = RD_DRIVE;
          cnt_inc   = 1'b1;
        end
      end
      RD_DRIVE: begin
        oe_c = 1'b1;
        if (fall) state_nxt = IDLE;
      end
      // Stop capturing once the fall is visible: the bus data is no longer valid.
      WR_WAIT: begin
        if (fall) state_nxt = WR_COMMIT;
        else      wr_cap    = 1'b1;
      end
      WR_COMMIT: begin
        ram_en_c  = 1'b1;
        ram_we_c  = 1'b1;
        cnt_inc   = 1'b1;
        state_nxt = IDLE;
      end
      MISS_WAIT: begin
        if (fall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hit_cnt <= '0;
    end else begin
      if (sample)  addr_q  <= bus.c64_addr[7:0];
      if (wr_cap)  wdata_q <= bus.c64_data_in;
      if (rd_cap)  rdata_q <= bus.ram_dout;
      if (cnt_inc) hit_cnt <= hit_cnt + 16'd1;
    end
  end

  assign bus.ram_en       = ram_en_c;
  assign bus.ram_we       = ram_we_c;
  assign bus.ram_addr     = addr_q;
  assign bus.ram_din      = wdata_q;
  assign bus.c64_data_out = rdata_q;
  assign bus.c64_data_oe  = oe_c;
  assign hit_count        = hit_cnt;
  assign state_dbg        = state;

endmodule

// File: doc/bridge_window_ctrl.md
BRIDGE_WINDOW_CTRL -- requirements
Module: bridge_window_ctrl

Interface
REQ-001 SHALL provide parameter WIN_PAGE, default 8'hDE, high address byte of the 256-byte window.
REQ-002 SHALL provide parameter SETTLE_CYC, default 2, clk cycles after detected phi2 rise before c64_addr/c64_rw are sampled (range 1..15).
REQ-003 SHALL provide port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL provide port phi2_in  input  1  C64 phi2, asynchronous to clk.
REQ-006 SHALL provide port c64_addr  input  16  C64 address bus.
REQ-007 SHALL provide port c64_rw  input  1  C64 R/W, 1 = read, 0 = write.
REQ-008 SHALL provide port c64_data_in  input  8  C64 data bus as driven by the CPU.
REQ-009 SHALL provide port win_enable  input  1  1 = window responds, 0 = all cycles ignored.
REQ-010 SHALL provide port c64_data_out  output  8  read data for the C64 bus.
REQ-011 SHALL provide port c64_data_oe  output  1  data bus drive enable.
REQ-012 SHALL provide port ram_addr  output  8  bridge RAM address.
REQ-013 SHALL provide port ram_din  output  8  bridge RAM write data.
REQ-014 SHALL provide port ram_dout  input  8  bridge RAM read data, valid one clk after ram_en.
REQ-015 SHALL provide port ram_en  output  1  bridge RAM enable strobe.
REQ-016 SHALL provide port ram_we  output  1  bridge RAM write strobe.
REQ-017 SHALL provide port hit_count  output  16  count of committed window accesses.

Function
REQ-018 SHALL synchronize phi2_in through two flops, then a third flop for edge detection; rise/fall events are one-clk pulses from the synced signal.
REQ-019 SHALL implement states IDLE, SETTLE, RD_ISSUE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_COMMIT, MISS_WAIT.
REQ-020 IDLE: on phi2 rise -> SETTLE with settle counter loaded to SETTLE_CYC-1; otherwise stay.
REQ-021 SETTLE: decrement counter; at zero, sample c64_addr, c64_rw into registers and decode hit = win_enable && addr[15:8]==WIN_PAGE.
REQ-022 At SETTLE exit: hit && read -> RD_ISSUE; hit && write -> WR_WAIT; no hit -> MISS_WAIT.
REQ-023 RD_ISSUE: ram_en=1, ram_we=0, ram_addr=latched addr[7:0] for exactly one clk -> RD_WAIT.
REQ-024 RD_WAIT: capture ram_dout into c64_data_out -> RD_DRIVE.
REQ-025 RD_DRIVE: c64_data_oe=1 held until phi2 fall detected, then oe=0 same cycle as return to IDLE.
REQ-026 c64_data_oe SHALL be 1 only in RD_DRIVE; never asserted for writes or misses.
REQ-027 WR_WAIT: register c64_data_in every clk; on phi2 fall -> WR_COMMIT (data used is last value registered while phi2 synced high).
REQ-028 WR_COMMIT: ram_en=1, ram_we=1, ram_din=registered data, ram_addr=latched addr[7:0] for one clk -> IDLE.
REQ-029 MISS_WAIT: no RAM strobes; on phi2 fall -> IDLE.
REQ-030 phi2 fall detected during SETTLE, RD_ISSUE or RD_WAIT SHALL abort to IDLE with no oe assertion; an already-issued read strobe is not retracted.
REQ-031 hit_count SHALL increment by 1 on each WR_COMMIT cycle and each RD_DRIVE entry, wrapping 16'hFFFF -> 16'h0000.
REQ-032 win_enable SHALL be sampled only at SETTLE exit; changes mid-access do not affect the current cycle.
REQ-033 ram_en/ram_we SHALL be 0 in every state other than RD_ISSUE and WR_COMMIT.
REQ-034 No RAM access SHALL occur more than once per phi2 cycle.

Reset
REQ-035 On rst: state IDLE, c64_data_out=8'h00, c64_data_oe=0, ram_en=0, ram_we=0, ram_addr=8'h00, ram_din=8'h00, hit_count=16'h0000, sync flops=0.
REQ-036 rst asserted mid-access SHALL drop oe and strobes the next clk edge; no write commits after rst.
REQ-037 After rst release, a phi2 already high SHALL not be treated as a rise until it goes low and high again.

Verification
REQ-038 Write: addr 16'hDE42, rw=0, data 8'hA5, phi2 high then low -> one clk ram_en=1, ram_we=1, ram_addr=8'h42, ram_din=8'hA5; hit_count=1.
REQ-039 Read: RAM[8'h10]=8'h3C, addr 16'hDE10, rw=1 -> single ram_en pulse, c64_data_out=8'h3C, oe=1 until phi2 fall, then 0.
REQ-040 Miss: addr 16'hD020 read and write -> no ram_en, oe stays 0, hit_count unchanged.
REQ-041 win_enable=0 with addr 16'hDE00 -> no strobes; set to 1 mid-cycle -> still no access that cycle.
REQ-042 Short phi2 high (fall before SETTLE completes, SETTLE_CYC=4) -> return to IDLE, oe never asserted.
REQ-043 Preload hit_count=16'hFFFF via 65535 accesses (or forced), one more write -> 16'h0000; rst during RD_DRIVE -> oe=0 next clk.
